// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH.
// A single memory port is shared between instruction fetch and data access
// through a req/ack handshake guarded by a wait-cycle timeout. All datapath
// enables are decoded from the current state plus the instruction fields
// latched in DECODE.

module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             format,
    input  logic [3:0]       opcode,
    input  logic             sign,
    input  logic             taken,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel_pc,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             regWrite,
    output logic [1:0]       writeSrc,
    output logic             cpin,
    output logic             cpout,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    // Opcode map for format=1 instructions
    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_LOAD   = 4'b0001;
    localparam logic [3:0] OP_STORE  = 4'b0010;
    localparam logic [3:0] OP_JUMP   = 4'b0011;
    localparam logic [3:0] OP_BRANCH = 4'b0100;
    localparam logic [3:0] OP_EPAR   = 4'b0101;
    localparam logic [3:0] OP_CP     = 4'b0111;
    localparam logic [3:0] OP_SHIFT  = 4'b1010;
    localparam logic [3:0] OP_HALT   = 4'b1011;

    // Register-file write source encodings
    localparam logic [1:0] WS_MEM = 2'b00;
    localparam logic [1:0] WS_IMM = 2'b01;
    localparam logic [1:0] WS_RES = 2'b10;
    localparam logic [1:0] WS_ALU = 2'b11;

    // Last wait-counter value a request may reach before it is declared dead
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Instruction classes; add and shift share the ALU class
    typedef enum logic [3:0] {
        CL_ALU    = 4'd0,
        CL_LOAD   = 4'd1,
        CL_STORE  = 4'd2,
        CL_JUMP   = 4'd3,
        CL_BRANCH = 4'd4,
        CL_EPAR   = 4'd5,
        CL_CP     = 4'd6,
        CL_HALT   = 4'd7,
        CL_IMM    = 4'd8
    } iclass_t;

    state_t           state_q;
    state_t           state_d;
    logic             fmt_q;
    logic [3:0]       op_q;
    logic             sign_q;
    logic [7:0]       wait_q;
    logic             fault_q;
    logic [CNT_W-1:0] count_q;
    logic             retire;
    logic             timeout;
    logic             wait_last;
    logic             dec_halt;
    iclass_t          cls_q;

    // Map format/opcode onto an instruction class; format=0 and unlisted
    // opcodes both write the immediate.
    function automatic iclass_t classify(input logic fmt, input logic [3:0] op);
        iclass_t c;
        c = CL_IMM;
        if (fmt) begin
            case (op)
                OP_ADD:    c = CL_ALU;
                OP_SHIFT:  c = CL_ALU;
                OP_LOAD:   c = CL_LOAD;
                OP_STORE:  c = CL_STORE;
                OP_JUMP:   c = CL_JUMP;
                OP_BRANCH: c = CL_BRANCH;
                OP_EPAR:   c = CL_EPAR;
                OP_CP:     c = CL_CP;
                OP_HALT:   c = CL_HALT;
                default:   c = CL_IMM;
            endcase
        end
        return c;
    endfunction

    // Halt is recognised from the live IR fields during DECODE; everything
    // after DECODE works from the latched copies only.
    assign dec_halt  = format && (opcode == OP_HALT);
    assign cls_q     = classify(fmt_q, op_q);
    assign wait_last = (wait_q == WAIT_LAST);

    assign halted      = (state_q == S_HALT);
    assign fault       = fault_q;
    assign instr_count = count_q;

    // Next-state and state-decoded datapath enables
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel_pc = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        regWrite    = 1'b0;
        writeSrc    = WS_MEM;
        cpin        = 1'b0;
        cpout       = 1'b0;
        retire      = 1'b0;
        timeout     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req     = 1'b1;
                addr_sel_pc = 1'b1;
                // An ack on the final allowed wait cycle still wins
                if (mem_ack) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_last) begin
                    timeout = 1'b1;
                    state_d = S_HALT;
                end
            end

            S_DECODE: begin
                state_d = dec_halt ? S_HALT : S_EXEC;
            end

            S_EXEC: begin
                case (cls_q)
                    CL_JUMP: begin
                        pc_load = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    CL_BRANCH: begin
                        pc_load = taken;
                        pc_inc  = !taken;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    CL_LOAD, CL_STORE, CL_EPAR: begin
                        state_d = S_MEM;
                    end
                    default: begin
                        state_d = S_WB;
                    end
                endcase
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls_q == CL_STORE);
                if (mem_ack) begin
                    if (cls_q == CL_STORE) begin
                        pc_inc  = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_last) begin
                    timeout = 1'b1;
                    state_d = S_HALT;
                end
            end

            S_WB: begin
                regWrite = 1'b1;
                pc_inc   = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
                case (cls_q)
                    CL_ALU, CL_EPAR: writeSrc = WS_ALU;
                    CL_LOAD:         writeSrc = WS_MEM;
                    CL_CP: begin
                        writeSrc = WS_RES;
                        cpout    = sign_q;
                        cpin     = !sign_q;
                    end
                    default:         writeSrc = WS_IMM;
                endcase
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State register, wait counter, sticky fault and retire counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            // Counter only runs while a request is outstanding, so it is
            // already zero whenever FETCH or MEM is entered.
            if (!mem_req || mem_ack || timeout) begin
                wait_q <= 8'd0;
            end else begin
                wait_q <= wait_q + 8'd1;
            end
            if (timeout) begin
                fault_q <= 1'b1;
            end
            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Capture the instruction fields once, in DECODE
    always_ff @(posedge clk) begin
        if (state_q == S_DECODE) begin
            fmt_q  <= format;
            op_q   <= opcode;
            sign_q <= sign;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer
// Cycle-level checks of multicycle_sequencer: an instruction-level model
// expands each instruction into its expected per-cycle outputs (table run in
// a loop), followed by hand-written timeout, halt and reset sequences.

`timescale 1ns/1ps

module tb_multicycle_sequencer;

    localparam int TMO = 16;
    localparam int CW  = 4;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_LOAD   = 4'b0001;
    localparam logic [3:0] OP_STORE  = 4'b0010;
    localparam logic [3:0] OP_JUMP   = 4'b0011;
    localparam logic [3:0] OP_BRANCH = 4'b0100;
    localparam logic [3:0] OP_EPAR   = 4'b0101;
    localparam logic [3:0] OP_UNL    = 4'b0110;
    localparam logic [3:0] OP_CP     = 4'b0111;
    localparam logic [3:0] OP_SHIFT  = 4'b1010;
    localparam logic [3:0] OP_HALT   = 4'b1011;

    localparam logic [1:0] WS_MEM = 2'b00;
    localparam logic [1:0] WS_IMM = 2'b01;
    localparam logic [1:0] WS_RES = 2'b10;
    localparam logic [1:0] WS_ALU = 2'b11;

    logic          clk;
    logic          rst_n;
    logic          format;
    logic [3:0]    opcode;
    logic          sign;
    logic          taken;
    logic          mem_ack;
    logic          mem_req;
    logic          mem_we;
    logic          addr_sel_pc;
    logic          ir_load;
    logic          pc_inc;
    logic          pc_load;
    logic          regWrite;
    logic [1:0]    writeSrc;
    logic          cpin;
    logic          cpout;
    logic          halted;
    logic          fault;
    logic [CW-1:0] instr_count;

    typedef struct packed {
        logic          mem_req;
        logic          mem_we;
        logic          addr_sel_pc;
        logic          ir_load;
        logic          pc_inc;
        logic          pc_load;
        logic          regWrite;
        logic [1:0]    writeSrc;
        logic          cpin;
        logic          cpout;
        logic          halted;
        logic          fault;
        logic [CW-1:0] cnt;
    } outs_t;

    typedef struct {
        bit         rst_n;
        bit         fmt;
        logic [3:0] op;
        bit         sg;
        bit         tk;
        bit         ack;
        outs_t      want;
        bit         chk;
        int         tag;
    } vec_t;

    outs_t       act;
    vec_t        vec[$];
    int          checks;
    int          errors;
    int          tag;
    int unsigned mcount;

    multicycle_sequencer #(
        .MEM_TIMEOUT(TMO),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .format     (format),
        .opcode     (opcode),
        .sign       (sign),
        .taken      (taken),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .addr_sel_pc(addr_sel_pc),
        .ir_load    (ir_load),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .regWrite   (regWrite),
        .writeSrc   (writeSrc),
        .cpin       (cpin),
        .cpout      (cpout),
        .halted     (halted),
        .fault      (fault),
        .instr_count(instr_count)
    );

    assign act = {mem_req, mem_we, addr_sel_pc, ir_load, pc_inc, pc_load,
                  regWrite, writeSrc, cpin, cpout, halted, fault, instr_count};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit rb();
        return bit'($urandom & 1);
    endfunction

    function automatic logic [3:0] r4();
        return 4'($urandom);
    endfunction

    function automatic string show(input outs_t o);
        return $sformatf("req=%b we=%b pcsel=%b ir=%b inc=%b ld=%b rw=%b ws=%b cpi=%b cpo=%b halt=%b flt=%b cnt=%0d",
                         o.mem_req, o.mem_we, o.addr_sel_pc, o.ir_load, o.pc_inc, o.pc_load,
                         o.regWrite, o.writeSrc, o.cpin, o.cpout, o.halted, o.fault, o.cnt);
    endfunction

    // Expected-output builders; all carry the model's retire count
    function automatic outs_t idle();
        outs_t e;
        e     = '0;
        e.cnt = CW'(mcount);
        return e;
    endfunction

    function automatic outs_t e_fetch(input bit ir);
        outs_t e;
        e             = idle();
        e.mem_req     = 1'b1;
        e.addr_sel_pc = 1'b1;
        e.ir_load     = ir;
        return e;
    endfunction

    function automatic outs_t e_mem(input bit we, input bit inc);
        outs_t e;
        e         = idle();
        e.mem_req = 1'b1;
        e.mem_we  = we;
        e.pc_inc  = inc;
        return e;
    endfunction

    function automatic outs_t e_halt(input bit flt);
        outs_t e;
        e        = idle();
        e.halted = 1'b1;
        e.fault  = flt;
        return e;
    endfunction

    // Drive one cycle at the falling edge, compare just after
    task automatic step(input vec_t v, input string nm);
        @(negedge clk);
        rst_n   = v.rst_n;
        format  = v.fmt;
        opcode  = v.op;
        sign    = v.sg;
        taken   = v.tk;
        mem_ack = v.ack;
        #1;
        if (v.chk) begin
            checks++;
            if (act !== v.want) begin
                errors++;
                $display("FAIL %s instr=%0d t=%0t got %s want %s",
                         nm, v.tag, $time, show(act), show(v.want));
            end
        end
    endtask

    task automatic hand(input string nm, input bit r, input bit f, input logic [3:0] op,
                        input bit s, input bit t, input bit a, input outs_t e, input bit c);
        vec_t v;
        v.rst_n = r;
        v.fmt   = f;
        v.op    = op;
        v.sg    = s;
        v.tk    = t;
        v.ack   = a;
        v.want  = e;
        v.chk   = c;
        v.tag   = tag;
        step(v, nm);
    endtask

    task automatic push(input bit f, input logic [3:0] op, input bit s, input bit t,
                        input bit a, input outs_t e);
        vec_t v;
        v.rst_n = 1'b1;
        v.fmt   = f;
        v.op    = op;
        v.sg    = s;
        v.tk    = t;
        v.ack   = a;
        v.want  = e;
        v.chk   = 1'b1;
        v.tag   = tag;
        vec.push_back(v);
    endtask

    // Instruction-level model: expand one instruction into its cycle records.
    // fd/md are the number of wait cycles before the fetch/data ack.
    // IR fields are random except in the DECODE cycle, and mem_ack is random
    // outside request cycles.
    task automatic add_instr(input bit f, input logic [3:0] op, input bit s, input bit tk,
                             input int fd, input int md);
        outs_t e;
        bit    is_mem;
        tag++;
        for (int i = 0; i <= fd; i++) begin
            push(rb(), r4(), rb(), rb(), i == fd, e_fetch(i == fd));
        end
        push(f, op, s, rb(), rb(), idle());
        if (f && op == OP_HALT) begin
            push(rb(), r4(), rb(), rb(), rb(), e_halt(1'b0));
            return;
        end
        e = idle();
        if (f && (op == OP_JUMP || op == OP_BRANCH)) begin
            if (op == OP_JUMP) begin
                e.pc_load = 1'b1;
            end else begin
                e.pc_load = tk;
                e.pc_inc  = !tk;
            end
            push(rb(), r4(), rb(), tk, rb(), e);
            mcount++;
            return;
        end
        push(rb(), r4(), rb(), tk, rb(), e);
        is_mem = f && (op == OP_LOAD || op == OP_STORE || op == OP_EPAR);
        if (is_mem) begin
            for (int i = 0; i <= md; i++) begin
                push(rb(), r4(), rb(), rb(), i == md,
                     e_mem(op == OP_STORE, (op == OP_STORE) && (i == md)));
            end
            if (op == OP_STORE) begin
                mcount++;
                return;
            end
        end
        e          = idle();
        e.regWrite = 1'b1;
        e.pc_inc   = 1'b1;
        if (!f) begin
            e.writeSrc = WS_IMM;
        end else begin
            case (op)
                OP_ADD, OP_SHIFT, OP_EPAR: e.writeSrc = WS_ALU;
                OP_LOAD:                   e.writeSrc = WS_MEM;
                OP_CP: begin
                    e.writeSrc = WS_RES;
                    e.cpout    = s;
                    e.cpin     = !s;
                end
                default:                   e.writeSrc = WS_IMM;
            endcase
        end
        push(rb(), r4(), rb(), rb(), rb(), e);
        mcount++;
    endtask

    initial begin
        bit         f;
        logic [3:0] op;
        int         fd;
        int         md;

        checks  = 0;
        errors  = 0;
        tag     = 0;
        mcount  = 0;
        rst_n   = 1'b0;
        format  = 1'b0;
        opcode  = 4'd0;
        sign    = 1'b0;
        taken   = 1'b0;
        mem_ack = 1'b0;

        hand("reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, idle(), 1'b0);
        hand("reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, idle(), 1'b0);

        // ---------------- table: directed instructions ----------------
        add_instr(1'b1, OP_ADD,    1'b0, 1'b0, 0, 0);
        add_instr(1'b1, OP_LOAD,   1'b0, 1'b0, 0, 2);
        add_instr(1'b1, OP_BRANCH, 1'b0, 1'b1, 0, 0);
        add_instr(1'b1, OP_BRANCH, 1'b0, 1'b0, 0, 0);
        add_instr(1'b1, OP_CP,     1'b1, 1'b0, 0, 0);
        add_instr(1'b1, OP_CP,     1'b0, 1'b0, 0, 0);
        add_instr(1'b1, OP_STORE,  1'b0, 1'b0, 1, 0);
        add_instr(1'b1, OP_JUMP,   1'b0, 1'b0, 0, 0);
        add_instr(1'b1, OP_EPAR,   1'b0, 1'b0, 0, 1);
        add_instr(1'b1, OP_SHIFT,  1'b0, 1'b0, 2, 0);
        add_instr(1'b0, OP_HALT,   1'b0, 1'b0, 0, 0);
        add_instr(1'b1, OP_UNL,    1'b0, 1'b0, 0, 0);
        add_instr(1'b0, OP_JUMP,   1'b0, 1'b0, 0, 0);
        add_instr(1'b1, OP_ADD,    1'b0, 1'b0, TMO - 1, 0);
        add_instr(1'b1, OP_LOAD,   1'b0, 1'b0, 0, TMO - 1);
        add_instr(1'b1, OP_STORE,  1'b0, 1'b0, 0, TMO - 1);

        // ---------------- table: randomized instructions ----------------
        for (int n = 0; n < 40; n++) begin
            f  = ($urandom % 4) != 0;
            op = r4();
            if (f && op == OP_HALT) op = OP_ADD;
            fd = (($urandom % 8) == 0) ? TMO - 1 : int'($urandom % 3);
            md = (($urandom % 8) == 0) ? TMO - 1 : int'($urandom % 3);
            add_instr(f, op, rb(), rb(), fd, md);
        end
        add_instr(1'b1, OP_HALT, 1'b0, 1'b0, 1, 0);

        for (int i = 0; i < vec.size(); i++) begin
            step(vec[i], "table");
        end

        // ---------------- halt holds, ack ignored, count frozen ----------------
        for (int i = 0; i < 4; i++) begin
            hand("halt_hold", 1'b1, rb(), r4(), rb(), rb(), i[0], e_halt(1'b0), 1'b1);
        end

        // ---------------- fetch timeout ----------------
        tag++;
        hand("reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, idle(), 1'b0);
        mcount = 0;
        for (int i = 0; i < TMO; i++) begin
            hand("tmo_req", 1'b1, rb(), r4(), rb(), rb(), 1'b0, e_fetch(1'b0), 1'b1);
        end
        hand("tmo_fault", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, e_halt(1'b1), 1'b1);
        for (int i = 0; i < 3; i++) begin
            hand("tmo_hold", 1'b1, rb(), r4(), rb(), rb(), rb(), e_halt(1'b1), 1'b1);
        end

        // ---------------- reset clears fault, then reset mid-transfer ----------------
        tag++;
        hand("reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, idle(), 1'b0);
        mcount = 0;
        hand("rst_fetch", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), 1'b1);
        hand("rst_dec",   1'b1, 1'b1, OP_ADD, 1'b0, 1'b0, 1'b0, idle(), 1'b1);
        hand("rst_exec",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, idle(), 1'b1);
        begin
            outs_t e;
            e          = idle();
            e.regWrite = 1'b1;
            e.pc_inc   = 1'b1;
            e.writeSrc = WS_ALU;
            hand("rst_wb", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, e, 1'b1);
        end
        mcount = 1;
        hand("mid_fetch", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), 1'b1);
        hand("mid_dec",   1'b1, 1'b1, OP_LOAD, 1'b0, 1'b0, 1'b0, idle(), 1'b1);
        hand("mid_exec",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, idle(), 1'b1);
        for (int i = 0; i < 3; i++) begin
            hand("mid_mem", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, e_mem(1'b0, 1'b0), 1'b1);
        end
        hand("reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, idle(), 1'b0);
        mcount = 0;
        hand("late_ack",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), 1'b1);
        hand("late_dec",  1'b1, 1'b1, OP_JUMP, 1'b0, 1'b0, 1'b0, idle(), 1'b1);
        begin
            outs_t e;
            e         = idle();
            e.pc_load = 1'b1;
            hand("late_jump", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, e, 1'b1);
        end
        mcount = 1;
        hand("late_next", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0), 1'b1);

        // ---------------- data-phase timeout on a store ----------------
        tag++;
        hand("mt_fetch", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), 1'b1);
        hand("mt_dec",   1'b1, 1'b1, OP_STORE, 1'b0, 1'b0, 1'b0, idle(), 1'b1);
        hand("mt_exec",  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, idle(), 1'b1);
        for (int i = 0; i < TMO; i++) begin
            hand("mt_req", 1'b1, rb(), r4(), rb(), rb(), 1'b0, e_mem(1'b1, 1'b0), 1'b1);
        end
        hand("mt_fault", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, e_halt(1'b1), 1'b1);

        // ---------------- reset returns everything to reset values ----------------
        hand("reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, idle(), 1'b0);
        mcount = 0;
        hand("reset_vals", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer that replaces single-cycle decode with a state machine. It steps the datapath through fetch, decode, execute, memory and writeback, and shares one memory port between instruction fetch and data access through a req/ack handshake. It sits between the instruction register fields (format, opcode, sign) and the datapath enables: PC, IR, register file, copy paths and memory.

## Interface
- MEM_TIMEOUT, 16: maximum cycles `mem_req` may wait for `mem_ack` before faulting (2..255).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- format  in  1  instruction format bit (0 = res/immediate, 1 = opcode form); valid from the cycle after `ir_load`.
- opcode  in  4  instruction opcode; valid from the cycle after `ir_load`.
- sign  in  1  cp direction (1 = cpout, 0 = cpin); valid from the cycle after `ir_load`.
- taken  in  1  branch condition from the ALU; sampled in EXEC.
- mem_ack  in  1  memory transfer complete; may be high in the same cycle as `mem_req`.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write (store), 0 = read.
- addr_sel_pc  out  1  1 = memory address from PC (fetch), 0 = from ALU.
- ir_load  out  1  load IR from memory data.
- pc_inc  out  1  PC <= PC+1.
- pc_load  out  1  PC <= branch/jump target.
- regWrite  out  1  register file write enable.
- writeSrc  out  2  write source: 11 ALU, 00 MEM, 01 IMM, 10 RES.
- cpin  out  1  copy res into register.
- cpout  out  1  copy register out to res.
- halted  out  1  core stopped.
- fault  out  1  memory timeout occurred.
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

## Operation
- Opcodes: add 0000, load 0001, store 0010, jump 0011, branch 0100, epar 0101, cp 0111, shift 1010, halt 1011. Any other opcode with format=1 is treated as an IMM-write instruction.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Drives `mem_req`=1, `mem_we`=0, `addr_sel_pc`=1.
  - When `mem_ack`=1: pulse `ir_load` and go to DECODE.
- DECODE: one cycle; latches format, opcode and sign into internal registers. All later states use only the latched copies.
  - halt with format=1 -> HALT.
  - Otherwise -> EXEC.
- EXEC, one cycle:
  - jump: `pc_load`=1, retire, -> FETCH.
  - branch: `pc_load`=taken, `pc_inc`=!taken, retire, -> FETCH.
  - load, store, epar: -> MEM.
  - All others, including format=0: -> WB.
- MEM:
  - Drives `mem_req`=1, `addr_sel_pc`=0, `mem_we`=1 only for store.
  - On ack: store does `pc_inc`, retire, -> FETCH; load and epar -> WB.
- WB, one cycle: `regWrite`=1, `pc_inc`=1, retire, -> FETCH. `writeSrc` is:
  - IMM for format=0 and for unlisted opcodes.
  - ALU for add, shift and epar.
  - MEM for load.
  - RES for cp, together with a `cpout` pulse (sign=1) or a `cpin` pulse (sign=0).
- Retire: `instr_count` increments by 1 in the same cycle as the transition to FETCH.
- HALT: `halted`=1, all enables 0. The block leaves HALT only on reset.
- Timeout:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle `mem_req` is high without ack.
  - When it reaches MEM_TIMEOUT-1 with no ack, the block sets `fault`=1 and goes to HALT. `fault` is sticky until reset.
- Outside WB: `regWrite`, `cpin` and `cpout` are 0, and `writeSrc`=00. Every output not listed for a state is 0.

## Timing
- Reset (rst_n=0 at an edge):
  - State becomes FETCH, wait counter 0, `instr_count`=0, `halted`=0, `fault`=0.
  - All pulse outputs deassert. Because outputs are state-decoded, `mem_req`=1 in the first cycle after reset.
- Reset mid-transfer aborts the transfer without a retire; a late `mem_ack` after reset is treated as the fetch ack.
- Latency with zero-wait memory (ack in the same cycle as req):
  - ALU/res/cp: 4 cycles.
  - load and epar: 5 cycles.
  - store: 4 cycles.
  - jump and branch: 3 cycles.
  - halt: `halted`=1 in the 3rd cycle.
- Each wait cycle adds 1 cycle.
- `mem_req` stays high continuously until the ack cycle and drops the cycle after. `mem_we` and `addr_sel_pc` are stable throughout the request.
- Ack on the exact timeout cycle: the ack wins and no fault is raised.
- `mem_ack` outside FETCH/MEM is ignored.
- `instr_count` wraps from all-ones to 0 without a flag.

## Test plan
- Reset, then feed add (format=1, op=0000) with zero-wait ack -> states F,D,E,W. In W, `regWrite`=1 and `writeSrc`=11. `instr_count`=1 after 4 cycles.
- load with 2-cycle ack delay in MEM -> `mem_req` high 3 cycles with `mem_we`=0 and `addr_sel_pc`=0. Then WB with `writeSrc`=00. Total 7 cycles.
- branch with taken=1, then with taken=0 -> `pc_load` pulses once in EXEC, then `pc_inc` pulses once in EXEC. `regWrite` stays 0 throughout.
- cp with sign=1, then sign=0 -> WB shows `cpout`=1 then `cpin`=1, `writeSrc`=10, the other copy signal 0.
- `mem_ack` held low in FETCH with MEM_TIMEOUT=16 -> `fault`=1 and `halted`=1 after 16 request cycles, stable until `rst_n`=0, after which all outputs return to reset values.
- halt opcode 1011 -> `halted`=1, `instr_count` unchanged, no `mem_req` afterwards. Toggling `mem_ack` has no effect.
